timer_peripheral: RTL and testbench



---
 rtl/timer_peripheral.sv | 125 ++++++++++++
 tb/tb_timer_peripheral.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/timer_peripheral.sv
// timer_peripheral: memory-mapped 32-bit interval timer driving the CPU IRQ.
// Window 0x4000_000x: TH (+0), TL (+4), TCON (+8), PRE (+C).
// Optional prescaler is compiled in with `define TIMER_PRESCALE_EN; without it
// the PRE slot reads 0, ignores writes and no prescaler flops exist.
module timer_peripheral (
   input  logic        clk,
   input  logic        reset,
   input  logic        rd,
   input  logic        wr,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic        kernel,
   output logic [31:0] rdata,
   output logic        irqout
);

   localparam logic [27:0] WIN_BASE = 28'h4000_000;

   logic [31:0] th_q, th_d;
   logic [31:0] tl_q, tl_d;
   logic [2:0]  tcon_q, tcon_d;

   logic        in_win;
   logic        wr_th, wr_tl, wr_tcon;
   logic        tick, overflow, status_set;
   logic        unused_addr;

   assign in_win      = (addr[31:4] == WIN_BASE);
   assign wr_th       = wr && in_win && (addr[3:2] == 2'd0);
   assign wr_tl       = wr && in_win && (addr[3:2] == 2'd1);
   assign wr_tcon     = wr && in_win && (addr[3:2] == 2'd2);
   assign unused_addr = ^addr[1:0];

`ifdef TIMER_PRESCALE_EN
   logic [15:0] pre_q, pre_d;
   logic [15:0] pcnt_q, pcnt_d;
   logic        wr_pre;

   assign wr_pre = wr && in_win && (addr[3:2] == 2'd3);
   // A tick fires when the prescale count reaches PRE; PRE=0 ticks every cycle
   assign tick   = tcon_q[0] && (pcnt_q == pre_q);

   // Prescaler next state: PRE write restarts the count, disabled timer freezes it
   always_comb begin
      pre_d  = pre_q;
      pcnt_d = pcnt_q;
      if (wr_pre) begin
         pre_d  = wdata[15:0];
         pcnt_d = '0;
      end else if (tcon_q[0]) begin
         pcnt_d = (pcnt_q == pre_q) ? 16'd0 : pcnt_q + 16'd1;
      end
   end

   // Prescaler registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pre_q  <= '0;
         pcnt_q <= '0;
      end else begin
         pre_q  <= pre_d;
         pcnt_q <= pcnt_d;
      end
   end
`else
   assign tick = tcon_q[0];
`endif

   // Overflow reloads TL from TH instead of incrementing; status only if enabled
   assign overflow   = tick && (tl_q == 32'hFFFF_FFFF);
   assign status_set = overflow && tcon_q[1];

   // Register next state: bus writes win over counting, status never lost
   always_comb begin
      th_d   = th_q;
      tl_d   = tl_q;
      tcon_d = tcon_q;
      if (wr_th)
         th_d = wdata;
      if (wr_tl)
         tl_d = wdata;
      else if (overflow)
         tl_d = th_q;
      else if (tick)
         tl_d = tl_q + 32'd1;
      if (wr_tcon)
         tcon_d = {wdata[2] | status_set, wdata[1:0]};
      else if (status_set)
         tcon_d[2] = 1'b1;
   end

   // Timer state registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         th_q   <= '0;
         tl_q   <= '0;
         tcon_q <= '0;
      end else begin
         th_q   <= th_d;
         tl_q   <= tl_d;
         tcon_q <= tcon_d;
      end
   end

   // Combinational read mux; anything outside the window or without rd reads 0
   always_comb begin
      rdata = '0;
      if (rd && in_win) begin
         case (addr[3:2])
            2'd0:    rdata = th_q;
            2'd1:    rdata = tl_q;
            2'd2:    rdata = {29'd0, tcon_q};
`ifdef TIMER_PRESCALE_EN
            default: rdata = {16'd0, pre_q};
`else
            default: rdata = '0;
`endif
         endcase
      end
   end

   // Kernel mode masks the request without touching the latched status
   assign irqout = tcon_q[1] & tcon_q[2] & ~kernel;

endmodule

// File: tb/tb_timer_peripheral.sv
// Scoreboard bench for timer_peripheral: stimulus pushes hand-computed
// expectations, a negedge monitor pops and compares whenever a read (or an
// irq check strobe) is presented.
module tb_timer_peripheral;

   localparam logic [31:0] A_TH   = 32'h4000_0000;
   localparam logic [31:0] A_TL   = 32'h4000_0004;
   localparam logic [31:0] A_TCON = 32'h4000_0008;
   localparam logic [31:0] A_PRE  = 32'h4000_000C;

   logic        clk = 1'b0;
   logic        reset;
   logic        rd, wr, kernel;
   logic [31:0] addr, wdata;
   logic [31:0] rdata;
   logic        irqout;
   logic        irq_chk;

   int          n_tests = 0;
   int          n_fail  = 0;

   logic [31:0] rd_exp_q[$];
   string       rd_name_q[$];
   logic        irq_exp_q[$];
   string       irq_name_q[$];

   timer_peripheral dut (
      .clk    (clk),
      .reset  (reset),
      .rd     (rd),
      .wr     (wr),
      .addr   (addr),
      .wdata  (wdata),
      .kernel (kernel),
      .rdata  (rdata),
      .irqout (irqout)
   );

   always #5 clk = ~clk;

   // Monitor: compare presented outputs against the scoreboard heads
   always @(negedge clk) begin
      if (rd) begin
         n_tests++;
         if (rd_exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL rd_unexpected: rdata=%h with empty scoreboard", rdata);
         end else begin
            logic [31:0] e;
            string       nm;
            e  = rd_exp_q.pop_front();
            nm = rd_name_q.pop_front();
            if (rdata !== e) begin
               n_fail++;
               $display("FAIL %s: rdata=%h expected %h", nm, rdata, e);
            end
         end
      end
      if (irq_chk) begin
         n_tests++;
         if (irq_exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL irq_unexpected: irqout=%b with empty scoreboard", irqout);
         end else begin
            logic  e;
            string nm;
            e  = irq_exp_q.pop_front();
            nm = irq_name_q.pop_front();
            if (irqout !== e) begin
               n_fail++;
               $display("FAIL %s: irqout=%b expected %b", nm, irqout, e);
            end
         end
      end
   end

   // Watchdog so the run always ends
   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic write_reg(input logic [31:0] a, input logic [31:0] d);
      wr = 1'b1; addr = a; wdata = d;
      @(posedge clk); #1;
      wr = 1'b0;
   endtask

   task automatic read_reg(input logic [31:0] a, input logic [31:0] e, input string nm,
                           input logic chk, input logic ie);
      rd = 1'b1; addr = a;
      rd_exp_q.push_back(e);
      rd_name_q.push_back(nm);
      if (chk) begin
         irq_chk = 1'b1;
         irq_exp_q.push_back(ie);
         irq_name_q.push_back({nm, "_irq"});
      end
      @(posedge clk); #1;
      rd = 1'b0; irq_chk = 1'b0;
   endtask

   initial begin
      reset = 1'b0; rd = 1'b0; wr = 1'b0; kernel = 1'b0; irq_chk = 1'b0;
      addr = '0; wdata = '0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;

      // Reset state
      read_reg(A_TH,   32'h0, "rst_th",   1'b1, 1'b0);
      read_reg(A_TL,   32'h0, "rst_tl",   1'b0, 1'b0);
      read_reg(A_TCON, 32'h0, "rst_tcon", 1'b0, 1'b0);
      read_reg(A_PRE,  32'h0, "rst_pre",  1'b0, 1'b0);

      // Async reset mid-count
      write_reg(A_TCON, 32'h1);
      repeat (3) @(posedge clk);
      #3 reset = 1'b0;
      @(posedge clk); #1;
      read_reg(A_TL,   32'h0, "midrst_tl",   1'b0, 1'b0);
      read_reg(A_TCON, 32'h0, "midrst_tcon", 1'b0, 1'b0);
      reset = 1'b1;
      @(posedge clk); #1;
      read_reg(A_TL,   32'h0, "postrst_tl_idle", 1'b0, 1'b0);

      // Overflow / reload with period 4
      write_reg(A_TH,   32'hFFFF_FFFC);
      write_reg(A_TL,   32'hFFFF_FFFC);
      write_reg(A_TCON, 32'h3);
      read_reg(A_TL,   32'hFFFF_FFFC, "cnt_c0", 1'b1, 1'b0);  // cycle 0
      read_reg(A_TL,   32'hFFFF_FFFD, "cnt_c1", 1'b0, 1'b0);  // 1
      read_reg(A_TL,   32'hFFFF_FFFE, "cnt_c2", 1'b0, 1'b0);  // 2
      read_reg(A_TL,   32'hFFFF_FFFF, "cnt_c3", 1'b1, 1'b0);  // 3
      read_reg(A_TL,   32'hFFFF_FFFC, "reload1", 1'b1, 1'b1); // 4
      read_reg(A_TCON, 32'h7,         "tcon_status", 1'b0, 1'b0); // 5
      read_reg(A_TL,   32'hFFFF_FFFE, "p_c6", 1'b0, 1'b0);    // 6
      read_reg(A_TL,   32'hFFFF_FFFF, "p_c7", 1'b0, 1'b0);    // 7
      read_reg(A_TL,   32'hFFFF_FFFC, "reload2", 1'b0, 1'b0); // 8

      // Kernel masking
      kernel = 1'b1;
      read_reg(A_TCON, 32'h7, "kern_mask", 1'b1, 1'b0);       // 9
      kernel = 1'b0;
      read_reg(A_TCON, 32'h7, "kern_unmask", 1'b1, 1'b1);     // 10

      // Clear on the overflow edge: status must survive
      write_reg(A_TCON, 32'h3);                               // 11 (edge 12 overflows)
      read_reg(A_TCON, 32'h7, "clr_vs_ovf", 1'b1, 1'b1);      // 12
      write_reg(A_TCON, 32'h3);                               // 13 plain clear
      read_reg(A_TCON, 32'h3, "ack_clear", 1'b1, 1'b0);       // 14
      @(posedge clk); #1;                                     // 15, edge 16 overflows
      read_reg(A_TCON, 32'h7, "status_again", 1'b1, 1'b1);    // 16

      // TL write while counting
      write_reg(A_TCON, 32'h1);                               // 17
      write_reg(A_TL,   32'h0000_1234);                       // 18
      read_reg(A_TL,   32'h0000_1234, "tl_wr_wins", 1'b0, 1'b0); // 19
      read_reg(A_TL,   32'h0000_1235, "tl_wr_inc",  1'b0, 1'b0); // 20
      read_reg(A_TCON, 32'h1, "tcon_ie_off", 1'b1, 1'b0);     // 21
      read_reg(A_TH,   32'hFFFF_FFFC, "th_hold", 1'b0, 1'b0);
      read_reg(32'h4000_0010, 32'h0, "out_of_window", 1'b0, 1'b0);

`ifdef TIMER_PRESCALE_EN
      write_reg(A_TCON, 32'h0);
      write_reg(A_PRE,  32'hABCD_0002);
      write_reg(A_TL,   32'h0);
      read_reg(A_PRE,  32'h2, "pre_rd", 1'b0, 1'b0);
      write_reg(A_TCON, 32'h1);
      read_reg(A_TL, 32'h0, "ps_c0", 1'b0, 1'b0);
      read_reg(A_TL, 32'h0, "ps_c1", 1'b0, 1'b0);
      read_reg(A_TL, 32'h0, "ps_c2", 1'b0, 1'b0);
      read_reg(A_TL, 32'h1, "ps_c3", 1'b0, 1'b0);
      read_reg(A_TL, 32'h1, "ps_c4", 1'b0, 1'b0);
      read_reg(A_TL, 32'h1, "ps_c5", 1'b0, 1'b0);
      read_reg(A_TL, 32'h2, "ps_c6", 1'b0, 1'b0);
      write_reg(A_PRE, 32'h0);
      read_reg(A_TL, 32'h2, "ps0_c8",  1'b0, 1'b0);
      read_reg(A_TL, 32'h3, "ps0_c9",  1'b0, 1'b0);
      read_reg(A_TL, 32'h4, "ps0_c10", 1'b0, 1'b0);
`else
      write_reg(A_TCON, 32'h0);
      write_reg(A_TL,   32'h0);
      write_reg(A_TCON, 32'h1);
      write_reg(A_PRE,  32'h5);                               // cycle 0
      read_reg(A_PRE, 32'h0, "pre_absent", 1'b0, 1'b0);       // 1
      read_reg(A_TL,  32'h2, "nops_c2", 1'b0, 1'b0);          // 2
      read_reg(A_TL,  32'h3, "nops_c3", 1'b0, 1'b0);          // 3
`endif

      repeat (2) @(posedge clk);
      if (rd_exp_q.size() != 0 || irq_exp_q.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL scoreboard_drain: %0d read and %0d irq expectations left, expected 0",
                  rd_exp_q.size(), irq_exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
